posit_sum_encode_es3: RTL and testbench
=======================================

Name: posit_sum_encode_es3

Overview:
- Converts the serialized raw sum produced by the product-accumulate adder into a rounded standard posit<32,3> word.
- Raw sum fields: sign, scale, normalized fraction, inf, zero, plus the adder's truncated flag.
- Sits directly after the adder's result/done/truncated outputs and is the encode end of the raw-value interface.
- Three-stage pipeline: regime build, field pack, round-to-nearest-even.
- Accepts one operand per cycle; no backpressure.

Parameters:
- FRAC_W, default AMBITS (package constant): width of the incoming normalized fraction field (hidden bit excluded, MSB first).
- NBITS, default 32: output posit width. Only 32 is supported.
- ES, default 3: exponent field width. Fixed at 3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  input valid; in and truncated are sampled on cycles where start=1.
- in  in  POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES3 (=FRAC_W+13)  raw sum, packed as {sgn[1], scale[10] signed, fraction[FRAC_W], inf[1], zero[1]}, MSB first.
- truncated  in  1  sticky: the adder discarded nonzero bits below the fraction.
- result  out  NBITS  encoded posit.
- done  out  1  result valid.

Behaviour:
- Reset: done=0, result=32'h0, all pipeline valid bits cleared. Reset asserted mid-flight drops every in-flight operand with no spurious done afterwards.
- Latency: exactly 3 cycles. start at edge t gives done=1 with result at edge t+3.
- Throughput: one result per cycle. done mirrors the start pattern delayed by 3. An X on start is treated as 0.
- result holds its last value while done=0.
- Stage 1 (register inputs, classify):
  - inf=1 → NaR (32'h80000000); this has priority over zero.
  - zero=1 → 32'h0.
  - Otherwise clamp scale to [-240, +240]; the saturate flag is set if clamping occurred.
  - k = scale >>> 3 (arithmetic shift); e = scale[2:0].
- Stage 2 (pack):
  - Regime: k≥0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - Concatenate {regime, e[2:0], fraction, truncated} into a left-aligned 64-bit buffer.
  - Take the top 31 bits as the magnitude.
  - guard = next bit below the magnitude; sticky = OR of all remaining bits and truncated.
- Stage 3 (round, sign):
  - Round to nearest, ties to even: increment if guard & (sticky | lsb).
  - A nonzero value never rounds to 0; the minimum magnitude is 31'h1.
  - Magnitude never reaches NaR; saturate at 31'h7FFFFFFF.
  - If sgn=1, result = two's complement of {0, magnitude}.
  - The zero/NaR special codes bypass rounding and sign handling.
- Simultaneous start and rst: rst wins and the operand is discarded.

Optional Feature:
- Macro: POSIT_SUM_ENCODE_FLAGS_EN.
- When defined:
  - Adds output ports inexact (1 bit) and saturated (1 bit), aligned with done. Both reset to 0.
  - inexact = guard|sticky for a finite nonzero result.
  - saturated = scale was clamped, or rounding was pinned to minpos/maxpos.
- When undefined: the ports and their logic are absent; result and done behave identically.

Decomposition:
- Package posit_defines_es3 receives:
  - typedef value_prod_sum (if not already present);
  - constants POSIT_ES3_NBITS=32, POSIT_ES3_MAXSCALE=240, POSIT_NAR_32=32'h80000000.
- One sub-module: posit_round_rne, the combinational stage-3 rounder (magnitude, guard, sticky, sign → result), reusable by future encoders.
- Shifting reuses the existing shift_right block.

Test Plan:
- sgn=0, scale=0, fraction=0, start pulse → done after 3 cycles, result=32'h40000000. Same input with sgn=1 → 32'hC0000000.
- scale=+1 → 32'h44000000. scale=-1 → 32'h3C000000.
- scale=0, only fraction bit 26 below the MSB set (half ULP), truncated=0 → 32'h40000000 (tie to even). Same with truncated=1 → 32'h40000001.
- scale=+300 → 32'h7FFFFFFF. scale=-300, nonzero → 32'h00000001. sgn=1 with scale=+300 → 32'h80000001.
- inf=1 → 32'h80000000. zero=1 → 32'h0. inf=1 and zero=1 together → 32'h80000000.
- Back-to-back starts for 8 cycles with rst asserted on cycle 4 → only results for operands accepted after reset are produced; no done for the flushed ones; done pattern equals start delayed by 3.

Source files
------------

// File: rtl/posit_sum_encode_es3_pkg.sv
// Shared definitions for the es=3 posit raw-value interface: the serialized
// adder sum layout, posit<32,3> constants, and the operand class used by the
// encode pipeline.
package posit_defines_es3;

  // Normalized fraction width carried by the product-accumulate adder.
  localparam int AMBITS = 28;

  localparam int          POSIT_ES3_NBITS    = 32;
  localparam int          POSIT_ES3_MAXSCALE = 240;
  localparam logic [31:0] POSIT_NAR_32       = 32'h8000_0000;

  // {sgn, scale[10], fraction[AMBITS], inf, zero}
  localparam int POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES3 = AMBITS + 13;

  typedef struct packed {
    logic                sgn;
    logic signed [9:0]   scale;
    logic [AMBITS-1:0]   frac;
    logic                inf;
    logic                zero;
  } value_prod_sum;

  // Operand class decided in stage 1; only KIND_NUM goes through rounding.
  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_NAR  = 2'd2
  } value_kind_e;

endpackage

// File: rtl/posit_sum_encode_es3_round.sv
// posit_round_rne: combinational round-to-nearest-even of a posit magnitude,
// with minpos/maxpos pinning and sign application. Shared by posit encoders.
module posit_round_rne #(
  parameter int NBITS = 32
) (
  input  logic [NBITS-2:0] i_mag,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic             i_sgn,
  output logic [NBITS-1:0] o_result
);

  localparam int MAG_W = NBITS - 1;

  logic             w_inc;
  logic [NBITS-1:0] w_sum;
  logic [MAG_W-1:0] w_mag;

  // Round, pin into [minpos, maxpos], then negate for negative values
  always_comb begin
    w_inc = i_guard & (i_sticky | i_mag[0]);
    w_sum = {1'b0, i_mag} + NBITS'(w_inc);
    if (w_sum[NBITS-1]) begin
      // Carry out of the magnitude would land on NaR; hold at maxpos.
      w_mag = '1;
    end else if (w_sum[MAG_W-1:0] == '0) begin
      // A finite nonzero value must stay nonzero; hold at minpos.
      w_mag = MAG_W'(1);
    end else begin
      w_mag = w_sum[MAG_W-1:0];
    end
    o_result = i_sgn ? -{1'b0, w_mag} : {1'b0, w_mag};
  end

endmodule

// File: rtl/posit_sum_encode_es3.sv
// posit_sum_encode_es3: encodes the adder's serialized raw sum into a rounded
// posit<32,3> word. Three pipeline stages (classify/clamp, regime pack,
// round), one operand per cycle, no backpressure.
// Optional macro POSIT_SUM_ENCODE_FLAGS_EN adds inexact/saturated outputs.
module posit_sum_encode_es3
  import posit_defines_es3::*;
#(
  parameter int FRAC_W = AMBITS,
  parameter int NBITS  = POSIT_ES3_NBITS,
  parameter int ES     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAC_W+12:0] in,
  input  logic               truncated,
  output logic [NBITS-1:0]   result,
  output logic               done
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
  ,
  output logic               inexact,
  output logic               saturated
`endif
);

  localparam int MAG_W  = NBITS - 1;
  // Regime terminator, exponent, fraction and truncated bit follow the run.
  localparam int TAIL_W = FRAC_W + ES + 2;
  // Room for the longest regime run (31) ahead of the tail, so nothing falls off.
  localparam int BUF_W  = (TAIL_W + 31 > 64) ? TAIL_W + 31 : 64;

  localparam logic signed [9:0] SCALE_HI = 10'(POSIT_ES3_MAXSCALE);
  localparam logic signed [9:0] SCALE_LO = -SCALE_HI;

  // ---------------- stage 1: unpack, classify, clamp ----------------
  logic                w_sgn;
  logic signed [9:0]   w_scale;
  logic [FRAC_W-1:0]   w_frac;
  logic                w_inf;
  logic                w_zero;
  logic signed [9:0]   w_scale_c;
  logic signed [5:0]   w_k;
  logic [ES-1:0]       w_e;
  value_kind_e         w_kind;

  assign {w_sgn, w_scale, w_frac, w_inf, w_zero} = in;

  // Clamp the scale into the representable regime range
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_scale_c = w_scale;
    if (w_scale > SCALE_HI) begin
      w_scale_c = SCALE_HI;
    end else if (w_scale < SCALE_LO) begin
      w_scale_c = SCALE_LO;
    end
  end

  assign w_k = 6'(w_scale_c >>> ES);
  assign w_e = w_scale_c[ES-1:0];

  // Classify the operand; NaR outranks zero when both flags are raised
  always_comb begin
    w_kind = KIND_NUM;
    if (w_zero) w_kind = KIND_ZERO;
    if (w_inf)  w_kind = KIND_NAR;
  end

  logic                r_s1_valid;
  value_kind_e         r_s1_kind;
  logic                r_s1_sgn;
  logic signed [5:0]   r_s1_k;
  logic [ES-1:0]       r_s1_e;
  logic [FRAC_W-1:0]   r_s1_frac;
  logic                r_s1_trunc;

  // ---------------- stage 2: regime build and field pack ----------------
  logic [TAIL_W-1:0]   w_tail;
  logic [BUF_W-1:0]    w_base;
  logic [BUF_W-1:0]    w_buf;
  logic [4:0]          w_rlen;
  logic [MAG_W-1:0]    w_mag;
  logic                w_guard;
  logic                w_sticky;

  // Shift the tail right by the regime run length, filling with the run bit
  always_comb begin
    w_tail = {r_s1_k[5], r_s1_e, r_s1_frac, r_s1_trunc};
    w_base = {w_tail, {(BUF_W-TAIL_W){1'b0}}};
    w_rlen = r_s1_k[5] ? 5'(-r_s1_k) : 5'(r_s1_k + 6'sd1);
    w_buf  = w_base >> w_rlen;
    if (!r_s1_k[5]) begin
      w_buf = w_buf | ~({BUF_W{1'b1}} >> w_rlen);
    end
  end

  assign w_mag    = w_buf[BUF_W-1 -: MAG_W];
  assign w_guard  = w_buf[BUF_W-1-MAG_W];
  assign w_sticky = (|w_buf[BUF_W-2-MAG_W:0]) | r_s1_trunc;

  logic                r_s2_valid;
  value_kind_e         r_s2_kind;
  logic                r_s2_sgn;
  logic [MAG_W-1:0]    r_s2_mag;
  logic                r_s2_guard;
  logic                r_s2_sticky;

  // ---------------- stage 3: round and sign ----------------
  logic [NBITS-1:0]    w_rounded;
  logic [NBITS-1:0]    w_final;

  posit_round_rne #(.NBITS(NBITS)) u_round (
    .i_mag    (r_s2_mag),
    .i_guard  (r_s2_guard),
    .i_sticky (r_s2_sticky),
    .i_sgn    (r_s2_sgn),
    .o_result (w_rounded)
  );

  // Special codes bypass rounding and sign handling
  always_comb begin
    unique case (r_s2_kind)
      KIND_NAR:  w_final = NBITS'(POSIT_NAR_32);
      KIND_ZERO: w_final = '0;
      default:   w_final = w_rounded;
    endcase
  end

  logic                r_done;
  logic [NBITS-1:0]    r_result;

`ifdef POSIT_SUM_ENCODE_FLAGS_EN
  logic w_sat;
  logic w_pinned;
  logic r_s1_sat;
  logic r_s2_sat;
  logic r_inexact;
  logic r_saturated;

  assign w_sat    = (w_scale > SCALE_HI) | (w_scale < SCALE_LO);
  assign w_pinned = ((r_s2_mag == '0) & ~(r_s2_guard & r_s2_sticky)) |
                    ((&r_s2_mag) & r_s2_guard);
`endif

  // Valid chain and output register; reset flushes every in-flight operand
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
      r_inexact   <= 1'b0;
      r_saturated <= 1'b0;
`endif
    end else begin
      // An unknown start takes the else branch and is treated as idle.
      if (start) r_s1_valid <= 1'b1;
      else       r_s1_valid <= 1'b0;
      r_s2_valid <= r_s1_valid;
      r_done     <= r_s2_valid;
      if (r_s2_valid) begin
        r_result    <= w_final;
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
        r_inexact   <= (r_s2_kind == KIND_NUM) & (r_s2_guard | r_s2_sticky);
        r_saturated <= (r_s2_kind == KIND_NUM) & (r_s2_sat | w_pinned);
`endif
      end
    end
  end

  // Datapath stage registers, loaded only when their stage holds an operand
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid chain alone decides whether they are used.
    if (start) begin
      r_s1_kind  <= w_kind;
      r_s1_sgn   <= w_sgn;
      r_s1_k     <= w_k;
      r_s1_e     <= w_e;
      r_s1_frac  <= w_frac;
      r_s1_trunc <= truncated;
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
      r_s1_sat   <= w_sat;
`endif
    end
    if (r_s1_valid) begin
      r_s2_kind   <= r_s1_kind;
      r_s2_sgn    <= r_s1_sgn;
      r_s2_mag    <= w_mag;
      r_s2_guard  <= w_guard;
      r_s2_sticky <= w_sticky;
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
      r_s2_sat    <= r_s1_sat;
`endif
    end
  end

  assign result = r_result;
  assign done   = r_done;
`ifdef POSIT_SUM_ENCODE_FLAGS_EN
  assign inexact   = r_inexact;
  assign saturated = r_saturated;
`endif

endmodule

// File: tb/tb_posit_sum_encode_es3.sv
// Scoreboard bench for posit_sum_encode_es3: the driver pushes hand-computed
// results tagged with the cycle they are due; a negedge monitor pops and
// compares on done and checks result holding between outputs.
`timescale 1ns/1ps
module tb_posit_sum_encode_es3;
  import posit_defines_es3::*;

  localparam int FW = AMBITS;

  typedef struct {
    string           name;
    logic            sgn;
    int              scale;
    logic [FW-1:0]   frac;
    logic            inf;
    logic            zero;
    logic            trunc;
    logic [31:0]     res;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic                                              clk = 1'b0;
  logic                                              rst = 1'b1;
  logic                                              start = 1'b0;
  logic [POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES3-1:0] in_bus = '0;
  logic                                              truncated = 1'b0;
  logic [31:0]                                       result;
  logic                                              done;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_last = 32'h0;
  exp_t        sb[$];
  vec_t        vecs[$];

  posit_sum_encode_es3 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in_bus),
    .truncated (truncated),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input string name, input logic sgn, input int scale,
                              input logic [FW-1:0] frac, input logic inf, input logic zero,
                              input logic trunc, input logic [31:0] res);
    vec_t v;
    v.name = name; v.sgn = sgn; v.scale = scale; v.frac = frac;
    v.inf = inf; v.zero = zero; v.trunc = trunc; v.res = res;
    return v;
  endfunction

  // Drive one operand in the current window; with_rst raises rst alongside it
  task automatic drive(input vec_t v, input logic with_rst);
    value_prod_sum p;
    @(posedge clk); #1;
    p.sgn = v.sgn; p.scale = 10'(v.scale); p.frac = v.frac;
    p.inf = v.inf; p.zero = v.zero;
    in_bus = p; truncated = v.trunc; start = 1'b1; rst = with_rst;
    if (with_rst) begin
      // Anything due after this window is flushed by the reset edge.
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    end else begin
      sb.push_back('{name: v.name, res: v.res, cyc: cyc + 3});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
  endtask

  // Cycle counter and model of the reset clearing result
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) model_last = 32'h0;
  end

  // Monitor: compare due outputs, flag early/spurious done, check hold
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check({e.name, "_missing"}, 32'(done), 32'h1);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check({e.name, "_done"}, 32'(done), 32'h1);
      check(e.name, result, e.res);
      model_last = e.res;
    end else if (done !== 1'b0) begin
      check("spurious_done", 32'(done), 32'h0);
    end else begin
      check("hold", result, model_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("one",          1'b0,    0, '0,      1'b0, 1'b0, 1'b0, 32'h4000_0000));
    vecs.push_back(mk("neg_one",      1'b1,    0, '0,      1'b0, 1'b0, 1'b0, 32'hC000_0000));
    vecs.push_back(mk("scale_p1",     1'b0,    1, '0,      1'b0, 1'b0, 1'b0, 32'h4400_0000));
    vecs.push_back(mk("scale_m1",     1'b0,   -1, '0,      1'b0, 1'b0, 1'b0, 32'h3C00_0000));
    vecs.push_back(mk("tie_even",     1'b0,    0, FW'(2),  1'b0, 1'b0, 1'b0, 32'h4000_0000));
    vecs.push_back(mk("tie_trunc",    1'b0,    0, FW'(2),  1'b0, 1'b0, 1'b1, 32'h4000_0001));
    vecs.push_back(mk("tie_odd",      1'b0,    0, FW'(6),  1'b0, 1'b0, 1'b0, 32'h4000_0002));
    vecs.push_back(mk("sticky_only",  1'b0,    0, FW'(1),  1'b0, 1'b0, 1'b0, 32'h4000_0000));
    vecs.push_back(mk("frac_half",    1'b0,    0, {1'b1, {(FW-1){1'b0}}}, 1'b0, 1'b0, 1'b0, 32'h4200_0000));
    vecs.push_back(mk("scale_p8",     1'b0,    8, '0,      1'b0, 1'b0, 1'b0, 32'h6000_0000));
    vecs.push_back(mk("neg_scale_p8", 1'b1,    8, '0,      1'b0, 1'b0, 1'b0, 32'hA000_0000));
    vecs.push_back(mk("scale_m9",     1'b0,   -9, '0,      1'b0, 1'b0, 1'b0, 32'h1E00_0000));
    vecs.push_back(mk("sat_max",      1'b0,  300, '0,      1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF));
    vecs.push_back(mk("sat_min",      1'b0, -300, '0,      1'b0, 1'b0, 1'b0, 32'h0000_0001));
    vecs.push_back(mk("neg_sat_max",  1'b1,  300, '0,      1'b0, 1'b0, 1'b0, 32'h8000_0001));
    vecs.push_back(mk("neg_sat_min",  1'b1, -300, '0,      1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF));
    vecs.push_back(mk("edge_max",     1'b0,  240, '0,      1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF));
    vecs.push_back(mk("edge_min",     1'b0, -240, '0,      1'b0, 1'b0, 1'b0, 32'h0000_0001));
    vecs.push_back(mk("inf",          1'b0,    5, FW'(7),  1'b1, 1'b0, 1'b0, 32'h8000_0000));
    vecs.push_back(mk("zero",         1'b1,    5, FW'(7),  1'b0, 1'b1, 1'b1, 32'h0000_0000));
    vecs.push_back(mk("inf_and_zero", 1'b0,    0, '0,      1'b1, 1'b1, 1'b0, 32'h8000_0000));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", result, 32'h0);

    // Directed vectors, mixing back-to-back issue with idle gaps
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], 1'b0);
      if (i % 3 == 2) idle();
    end
    repeat (5) idle();

    // Eight back-to-back starts with rst raised alongside the fourth
    for (int i = 0; i < 8; i++) begin
      drive(mk($sformatf("rst_seq%0d", i), 1'b0, i, '0, 1'b0, 1'b0, 1'b0,
               32'h4000_0000 | (32'(i) << 26)), i == 3);
    end
    idle();

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    check("drain_pending", 32'(sb.size()), 32'h0);
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
